// File: rtl/scariv_ras_stack_if.sv
`default_nettype none
// ============================================================================
//  Module      : scariv_ras_stack_if
//  Description : Push/pop/flush request and prediction bundle for the
//                speculative return-address stack.
//  Revision    : 1.0  initial release
// ============================================================================
interface scariv_ras_stack_if #(
  parameter int ENTRY_SIZE = 32,
  parameter int VADDR_W    = 39
);
  localparam int PTR_W = $clog2(ENTRY_SIZE);
  localparam int CNT_W = PTR_W + 1;

  logic               i_push_valid;
  logic [VADDR_W-1:0] i_push_addr;
  logic               i_pop_valid;
  logic               i_flush_valid;
  logic [PTR_W-1:0]   i_flush_tos;
  logic [CNT_W-1:0]   i_flush_count;
  logic [PTR_W-1:0]   o_tos;
  logic [CNT_W-1:0]   o_count;
  logic               o_pred_valid;
  logic [VADDR_W-1:0] o_pred_addr;

  // Fetch-side predictor drives requests and samples the prediction
  modport master (
    output i_push_valid, i_push_addr, i_pop_valid,
    output i_flush_valid, i_flush_tos, i_flush_count,
    input  o_tos, o_count, o_pred_valid, o_pred_addr
  );

  // The stack itself
  modport slave (
    input  i_push_valid, i_push_addr, i_pop_valid,
    input  i_flush_valid, i_flush_tos, i_flush_count,
    output o_tos, o_count, o_pred_valid, o_pred_addr
  );
endinterface
`default_nettype wire

// File: rtl/scariv_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : scariv_ras_stack
//  Description : Speculative circular return-address stack. Calls push, returns
//                pop a registered prediction one cycle later, mispredict flush
//                restores a checkpointed (tos, count) pair.
//  Revision    : 1.0  initial release
// ============================================================================
module scariv_ras_stack #(
  parameter int ENTRY_SIZE = 32,
  parameter int VADDR_W    = 39
) (
  input  wire                  i_clk,
  input  wire                  i_reset,
  scariv_ras_stack_if.slave    ras_if
);
  localparam int PTR_W = $clog2(ENTRY_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(ENTRY_SIZE);

  logic [VADDR_W-1:0] entry_q [ENTRY_SIZE];
  logic [VADDR_W-1:0] entry_d [ENTRY_SIZE];
  logic [PTR_W-1:0]   tos_q, tos_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pred_valid_q, pred_valid_d;
  logic [VADDR_W-1:0] pred_addr_q, pred_addr_d;

  logic [PTR_W-1:0]   top_idx;
  logic               is_empty;
  logic               is_full;

  // Pointer arithmetic wraps naturally because ENTRY_SIZE is a power of two
  assign top_idx  = tos_q - PTR_W'(1);
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == C_FULL_CNT);

  // Next-state: flush wins, then the push/pop combination
  always_comb begin
    entry_d      = entry_q;
    tos_d        = tos_q;
    count_d      = count_q;
    pred_valid_d = 1'b0;
    pred_addr_d  = '0;
    if (ras_if.i_flush_valid) begin
      // Overwritten entries are not recovered; only the pointers are restored
      tos_d   = ras_if.i_flush_tos;
      count_d = ras_if.i_flush_count;
    end else if (ras_if.i_push_valid && ras_if.i_pop_valid && !is_empty) begin
      // Return-and-call: predict old top, then replace it in place
      pred_valid_d     = 1'b1;
      pred_addr_d      = entry_q[top_idx];
      entry_d[top_idx] = ras_if.i_push_addr;
    end else if (ras_if.i_push_valid) begin
      // When full the slot at tos holds the oldest entry and is overwritten
      entry_d[tos_q] = ras_if.i_push_addr;
      tos_d          = tos_q + PTR_W'(1);
      if (!is_full) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (ras_if.i_pop_valid && !is_empty) begin
      pred_valid_d = 1'b1;
      pred_addr_d  = entry_q[top_idx];
      tos_d        = top_idx;
      count_d      = count_q - CNT_W'(1);
    end
  end

  // State registers; reset clears storage and drops any in-flight prediction
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        entry_q[i] <= '0;
      end
      tos_q        <= '0;
      count_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_addr_q  <= '0;
    end else begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        entry_q[i] <= entry_d[i];
      end
      tos_q        <= tos_d;
      count_q      <= count_d;
      pred_valid_q <= pred_valid_d;
      pred_addr_q  <= pred_addr_d;
    end
  end

  assign ras_if.o_tos        = tos_q;
  assign ras_if.o_count      = count_q;
  assign ras_if.o_pred_valid = pred_valid_q;
  assign ras_if.o_pred_addr  = pred_addr_q;

`ifndef SYNTHESIS
  // Occupancy can never exceed the storage depth
  a_count_bound : assert property (@(posedge i_clk) disable iff (i_reset)
    count_q <= C_FULL_CNT);

  // A checkpoint larger than the stack cannot have been produced by this block
  a_flush_count_legal : assert property (@(posedge i_clk) disable iff (i_reset)
    ras_if.i_flush_valid |-> (ras_if.i_flush_count <= C_FULL_CNT));
`endif

endmodule
`default_nettype wire

// File: tb/tb_scariv_ras_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scariv_ras_stack
//  Description : Self-checking bench for scariv_ras_stack (vector table plus
//                hand-written overflow, flush and async-reset sequences).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scariv_ras_stack;
  localparam int ENTRY_SIZE = 32;
  localparam int VADDR_W    = 39;
  localparam int PTR_W      = 5;
  localparam int CNT_W      = 6;

  typedef struct {
    logic               push;
    logic [VADDR_W-1:0] addr;
    logic               pop;
    logic               flush;
    logic [PTR_W-1:0]   ftos;
    logic [CNT_W-1:0]   fcnt;
    logic               pv;
    logic [VADDR_W-1:0] pa;
    logic [PTR_W-1:0]   tos;
    logic [CNT_W-1:0]   cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_checks;
  int   n_fail;
  vec_t tbl[$];
  logic [VADDR_W:0] exp_q[$];

  scariv_ras_stack_if #(.ENTRY_SIZE(ENTRY_SIZE), .VADDR_W(VADDR_W)) ras_if ();

  scariv_ras_stack #(.ENTRY_SIZE(ENTRY_SIZE), .VADDR_W(VADDR_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .ras_if  (ras_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic push, input logic [VADDR_W-1:0] addr,
                              input logic pop, input logic flush,
                              input logic [PTR_W-1:0] ftos, input logic [CNT_W-1:0] fcnt,
                              input logic pv, input logic [VADDR_W-1:0] pa,
                              input logic [PTR_W-1:0] tos, input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.push = push; v.addr = addr; v.pop = pop; v.flush = flush;
    v.ftos = ftos; v.fcnt = fcnt; v.pv = pv; v.pa = pa; v.tos = tos; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ras_if.i_push_valid  = 1'b0;
    ras_if.i_push_addr   = '0;
    ras_if.i_pop_valid   = 1'b0;
    ras_if.i_flush_valid = 1'b0;
    ras_if.i_flush_tos   = '0;
    ras_if.i_flush_count = '0;
  endtask

  // Drive one cycle, queue the expected prediction, compare after the edge
  task automatic step(input vec_t v, input string tag);
    logic [VADDR_W:0] e;
    ras_if.i_push_valid  = v.push;
    ras_if.i_push_addr   = v.addr;
    ras_if.i_pop_valid   = v.pop;
    ras_if.i_flush_valid = v.flush;
    ras_if.i_flush_tos   = v.ftos;
    ras_if.i_flush_count = v.fcnt;
    exp_q.push_back({v.pv, v.pa});
    @(posedge clk);
    #1;
    n_vec++;
    e = exp_q.pop_front();
    check({tag, " pred_valid"}, 64'(ras_if.o_pred_valid), 64'(e[VADDR_W]));
    check({tag, " pred_addr"},  64'(ras_if.o_pred_addr),  64'(e[VADDR_W-1:0]));
    check({tag, " tos"},        64'(ras_if.o_tos),        64'(v.tos));
    check({tag, " count"},      64'(ras_if.o_count),      64'(v.cnt));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " pred_valid"}, 64'(ras_if.o_pred_valid), 64'd0);
    check({tag, " pred_addr"},  64'(ras_if.o_pred_addr),  64'd0);
    check({tag, " tos"},        64'(ras_if.o_tos),        64'd0);
    check({tag, " count"},      64'(ras_if.o_count),      64'd0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_checks = 0; n_fail = 0;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //          push addr     pop flush ftos fcnt pv pa       tos cnt
    // LIFO order, then underflow
    tbl.push_back(mk(1, 'h1000, 0, 0, 0, 0, 0, 'h0,    1, 1));
    tbl.push_back(mk(1, 'h2000, 0, 0, 0, 0, 0, 'h0,    2, 2));
    tbl.push_back(mk(1, 'h3000, 0, 0, 0, 0, 0, 'h0,    3, 3));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h3000, 2, 2));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h2000, 1, 1));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h1000, 0, 0));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 0, 'h0,    0, 0));
    // Checkpoint after 0xA0 is (tos=1,count=1); flush back to it
    tbl.push_back(mk(1, 'hA0,   0, 0, 0, 0, 0, 'h0,    1, 1));
    tbl.push_back(mk(1, 'hB0,   0, 0, 0, 0, 0, 'h0,    2, 2));
    tbl.push_back(mk(1, 'hC0,   0, 0, 0, 0, 0, 'h0,    3, 3));
    tbl.push_back(mk(0, 'h0,    0, 1, 1, 1, 0, 'h0,    1, 1));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'hA0,   0, 0));
    // Return-and-call on a non-empty stack
    tbl.push_back(mk(1, 'h3000, 0, 0, 0, 0, 0, 'h0,    1, 1));
    tbl.push_back(mk(1, 'h4000, 0, 0, 0, 0, 0, 'h0,    2, 2));
    tbl.push_back(mk(1, 'h5000, 1, 0, 0, 0, 1, 'h4000, 2, 2));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h5000, 1, 1));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h3000, 0, 0));
    // Return-and-call on an empty stack acts as a plain push
    tbl.push_back(mk(1, 'h6000, 1, 0, 0, 0, 0, 'h0,    1, 1));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h6000, 0, 0));
    // Flush masks a simultaneous push+pop; slot 3 must keep 0x40
    tbl.push_back(mk(1, 'h10,   0, 0, 0, 0, 0, 'h0,    1, 1));
    tbl.push_back(mk(1, 'h20,   0, 0, 0, 0, 0, 'h0,    2, 2));
    tbl.push_back(mk(1, 'h30,   0, 0, 0, 0, 0, 'h0,    3, 3));
    tbl.push_back(mk(1, 'h40,   0, 0, 0, 0, 0, 'h0,    4, 4));
    tbl.push_back(mk(1, 'h7000, 1, 1, 3, 3, 0, 'h0,    3, 3));
    tbl.push_back(mk(0, 'h0,    0, 1, 4, 4, 0, 'h0,    4, 4));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h40,   3, 3));
    tbl.push_back(mk(0, 'h0,    1, 0, 0, 0, 1, 'h30,   2, 2));
    tbl.push_back(mk(0, 'h0,    0, 0, 0, 0, 0, 'h0,    2, 2));
    // Flush during a pop suppresses the prediction
    tbl.push_back(mk(0, 'h0,    1, 1, 2, 2, 0, 'h0,    2, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // Overflow: 33 pushes into 32 slots, then drain
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      step(mk(1, VADDR_W'(k * 'h100), 0, 0, 0, 0, 0, '0,
              PTR_W'(k % ENTRY_SIZE), CNT_W'((k > ENTRY_SIZE) ? ENTRY_SIZE : k)),
           $sformatf("ovf_push%0d", k));
    end
    for (int i = 0; i < 32; i++) begin
      step(mk(0, '0, 1, 0, 0, 0, 1, VADDR_W'((33 - i) * 'h100),
              PTR_W'(1 - (i + 1)), CNT_W'(31 - i)),
           $sformatf("ovf_pop%0d", i));
    end
    step(mk(0, '0, 1, 0, 0, 0, 0, '0, 1, 0), "ovf_underflow");

    // Async reset mid-stream with a prediction on the outputs and a pop pending
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(mk(1, VADDR_W'(k * 'h11), 0, 0, 0, 0, 0, '0, PTR_W'(k), CNT_W'(k)),
           $sformatf("rst_push%0d", k));
    end
    step(mk(0, '0, 1, 0, 0, 0, 1, 'h55, 4, 4), "rst_pop");
    ras_if.i_pop_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(mk(0, '0, 1, 0, 0, 0, 0, '0, 0, 0), "post_reset_pop");

    drive_idle();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
